// File: rtl/mlp_neuron_acc.sv
// Neuron accumulate/activate stage: sums product beats, adds bias, rounds,
// saturates to OUT_W and emits one result per vector. Optional ReLU: MLP_ACC_RELU_EN.
module mlp_neuron_acc #(
   parameter int PROD_W     = 33,
   parameter int ACC_W      = 40,
   parameter int OUT_W      = 18,
   parameter int FRAC_SHIFT = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   input  logic              in_last,
   input  logic [OUT_W-1:0]  bias,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_ovf,
   output logic              busy
);

   localparam logic signed [ACC_W:0] LP_MAX =
      {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] LP_MIN =
      {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic signed [ACC_W:0] LP_HALF =
      {{(ACC_W+1-FRAC_SHIFT){1'b0}}, 1'b1, {(FRAC_SHIFT-1){1'b0}}};

   logic [ACC_W-1:0]  r_acc;
   logic              r_first;
   logic [OUT_W-1:0]  r_bias_q;
   logic              r_out_valid;
   logic [OUT_W-1:0]  r_out_data;
   logic              r_out_ovf;
   logic              r_busy;

   logic              w_accept;
   logic              w_load;
   logic [ACC_W-1:0]  w_prod_ext;
   logic [ACC_W-1:0]  w_sum;
   logic [OUT_W-1:0]  w_bias_eff;
   logic [ACC_W-1:0]  w_bias_ext;
   logic [ACC_W-1:0]  w_final;
   logic signed [ACC_W:0] w_rnd;
   logic signed [ACC_W:0] w_r;
   logic [OUT_W-1:0]  w_res;
   logic              w_ovf;

   // Stall the source only while a finished result is blocked downstream
   assign in_ready   = !(r_out_valid && !out_ready);
   assign w_accept   = in_valid && in_ready;
   assign w_load     = w_accept && in_last;

   assign w_prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
   assign w_sum      = (r_first ? '0 : r_acc) + w_prod_ext;
   assign w_bias_eff = r_first ? bias : r_bias_q;
   assign w_bias_ext = {{(ACC_W-OUT_W-FRAC_SHIFT){w_bias_eff[OUT_W-1]}},
                        w_bias_eff, {FRAC_SHIFT{1'b0}}};
   assign w_final    = w_sum + w_bias_ext;

   // Round half up one bit wider so the rounding add itself cannot wrap
   assign w_rnd = $signed({w_final[ACC_W-1], w_final}) + LP_HALF;
   assign w_r   = w_rnd >>> FRAC_SHIFT;

   // Clamp to the output range, then optionally rectify
   always_comb begin
      w_res = w_r[OUT_W-1:0];
      w_ovf = 1'b0;
      if (w_r > LP_MAX) begin
         w_res = LP_MAX[OUT_W-1:0];
         w_ovf = 1'b1;
      end else if (w_r < LP_MIN) begin
         w_res = LP_MIN[OUT_W-1:0];
         w_ovf = 1'b1;
      end
`ifdef MLP_ACC_RELU_EN
      if (w_res[OUT_W-1]) begin
         w_res = '0;
      end
`endif
   end

   // Accumulator, first-beat flag, latched bias and busy flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc    <= '0;
         r_first  <= 1'b1;
         r_bias_q <= '0;
         r_busy   <= 1'b0;
      end else if (w_accept) begin
         r_acc   <= in_last ? '0 : w_sum;
         r_first <= in_last;
         r_busy  <= !in_last;
         if (r_first) begin
            r_bias_q <= bias;
         end
      end
   end

   // Output register: reload on a last beat, clear when consumed, else hold
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ovf   <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_res;
         r_out_ovf   <= w_ovf;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ovf   = r_out_ovf;
   assign busy      = r_busy;

endmodule
